// File: rtl/bcdn_to_bin_if.sv
// rtl/bcdn_to_bin_if.sv - request/result bundle for the BCD-to-binary converter
interface bcdn_to_bin_if #(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
);
  logic                  start;
  logic [4*N_DIGITS-1:0] bcd;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic                  ovf;
  logic [BIN_W-1:0]      bin;

  modport master (output start, bcd, input  ready, done, err, ovf, bin);
  modport slave  (input  start, bcd, output ready, done, err, ovf, bin);
endinterface

// File: rtl/bcdn_to_bin.sv
// rtl/bcdn_to_bin.sv - packed BCD to binary converter, reverse double-dabble, one bit per clock
module bcdn_to_bin #(
  parameter int N_DIGITS = 4,
  parameter int BIN_W    = 14
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  bcdn_to_bin_if.slave  bus
);
  localparam int BCD_W = 4 * N_DIGITS;
  localparam int IW    = $clog2(BIN_W + 1);
  localparam logic [IW-1:0] IDX_INIT = IW'(BIN_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [BCD_W-1:0]   bcd_q;
  logic [IW-1:0]      idx;
  logic [BIN_W-1:0]   bin_q;
  logic               err_q;
  logic               ovf_q;
  logic               ready_q;
  logic               done_q;

  logic               bad_digit;
  logic [BCD_W-1:0]   shifted;
  logic [BCD_W-1:0]   adjusted;
  logic [BIN_W-1:0]   bin_next;

  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (bus.bcd[4*k +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Undo one doubling: halve the BCD vector, then any digit that received a
  // carried-in 8 (value >7) is corrected by -3 so it stays a valid decimal digit.
  always_comb begin
    shifted  = bcd_q >> 1;
    adjusted = shifted;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (shifted[4*k +: 4] > 4'd7) adjusted[4*k +: 4] = shifted[4*k +: 4] - 4'd3;
    end
  end

  assign bin_next = (bin_q >> 1) | (BIN_W'(bcd_q[0]) << (BIN_W - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      bcd_q   <= '0;
      idx     <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ready_q <= 1'b0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            if (bad_digit) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              err_q <= 1'b0;
              bcd_q <= bus.bcd;
              idx   <= IDX_INIT;
              state <= OP;
            end
          end
        end
        OP: begin
          bin_q <= bin_next;
          bcd_q <= adjusted;
          idx   <= idx - 1'b1;
          if (idx == IW'(1)) begin
            // Anything left in the BCD vector did not fit in BIN_W bits.
            ovf_q  <= (adjusted != '0);
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.ovf   = ovf_q;
  assign bus.bin   = bin_q;
endmodule

// File: tb/tb_bcdn_to_bin.sv
// tb/tb_bcdn_to_bin.sv - directed and scoreboard checks for bcdn_to_bin (4x14 and 3x8 instances)
module tb_bcdn_to_bin;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  bcdn_to_bin_if #(.N_DIGITS(4), .BIN_W(14)) bus_a ();
  bcdn_to_bin_if #(.N_DIGITS(3), .BIN_W(8))  bus_b ();

  bcdn_to_bin #(.N_DIGITS(4), .BIN_W(14)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
  bcdn_to_bin #(.N_DIGITS(3), .BIN_W(8))  dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  // One conversion on instance a (sel=0) or b (sel=1); cyc = 1 means done right after the accept edge.
  task automatic run(input bit sel, input logic [15:0] val, output int cyc,
                     output logic [13:0] bin, output logic err, output logic ovf,
                     output logic rdy_next);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(sel ? bus_b.ready : bus_a.ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sel) begin bus_b.bcd = val[11:0]; bus_b.start = 1'b1; end
    else     begin bus_a.bcd = val;       bus_a.start = 1'b1; end
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_a.bcd   = 16'hFFFF;
    bus_b.bcd   = 12'hFFF;
    cyc = 1;
    while (!(sel ? bus_b.done : bus_a.done) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    bin = sel ? {6'd0, bus_b.bin} : bus_a.bin;
    err = sel ? bus_b.err : bus_a.err;
    ovf = sel ? bus_b.ovf : bus_a.ovf;
    @(posedge clk);
    #1;
    rdy_next = sel ? bus_b.ready : bus_a.ready;
  endtask

  typedef struct {
    bit          sel;
    logic [15:0] val;
    logic [13:0] bin;
    logic        err;
    logic        ovf;
    int          cyc;
  } vec_t;

  vec_t vecs[7] = '{
    '{1'b0, 16'h1234, 14'h04D2, 1'b0, 1'b0, 15},
    '{1'b0, 16'h9999, 14'h270F, 1'b0, 1'b0, 15},
    '{1'b0, 16'h0000, 14'h0000, 1'b0, 1'b0, 15},
    '{1'b0, 16'h12A4, 14'h0000, 1'b1, 1'b0, 1},
    '{1'b0, 16'h0042, 14'h002A, 1'b0, 1'b0, 15},
    '{1'b1, 16'h0999, 14'h00E7, 1'b0, 1'b1, 9},
    '{1'b1, 16'h0255, 14'h00FF, 1'b0, 1'b0, 9}
  };

  initial begin
    int          cyc;
    logic [13:0] bin;
    logic        err, ovf, rdy;
    int          n_done, n_ready, guard;

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.bcd = '0;
    bus_b.start = 1'b0; bus_b.bcd = '0;
    #12;
    check("rst_ready", 32'(bus_a.ready), 32'd1);
    check("rst_done",  32'(bus_a.done),  32'd0);
    check("rst_bin",   32'(bus_a.bin),   32'd0);
    check("rst_flags", {30'd0, bus_a.err, bus_a.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run(vecs[i].sel, vecs[i].val, cyc, bin, err, ovf, rdy);
      check($sformatf("bin_%h", vecs[i].val), 32'(bin), 32'(vecs[i].bin));
      check($sformatf("err_%h", vecs[i].val), 32'(err), 32'(vecs[i].err));
      check($sformatf("ovf_%h", vecs[i].val), 32'(ovf), 32'(vecs[i].ovf));
      check($sformatf("lat_%h", vecs[i].val), 32'(cyc), 32'(vecs[i].cyc));
      check($sformatf("rdy_%h", vecs[i].val), 32'(rdy), 32'd1);
    end

    // start held high: one conversion per accept, 16-edge period
    @(negedge clk);
    bus_a.bcd = 16'h0007;
    bus_a.start = 1'b1;
    n_done = 0;
    n_ready = 0;
    for (int e = 0; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (e > 0 && bus_a.done)  n_done++;
      if (e > 0 && bus_a.ready) n_ready++;
    end
    bus_a.start = 1'b0;
    check("held_done_cnt",  32'(n_done),  32'd2);
    check("held_ready_cnt", 32'(n_ready), 32'd2);
    guard = 0;
    while (!bus_a.done && guard < 40) begin @(posedge clk); #1; guard++; end
    check("held_bin", 32'(bus_a.bin), 32'h7);

    // reset in the middle of OP
    @(negedge clk);
    bus_a.bcd = 16'h1234;
    bus_a.start = 1'b1;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("midop_bin_nonzero", 32'(bus_a.bin != 14'd0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(bus_a.ready), 32'd1);
    check("midrst_done",  32'(bus_a.done),  32'd0);
    check("midrst_bin",   32'(bus_a.bin),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      if (bus_a.done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    run(1'b0, 16'h0042, cyc, bin, err, ovf, rdy);
    check("post_rst_bin", 32'(bin), 32'h2A);
    check("post_rst_lat", 32'(cyc), 32'd15);

    // scoreboard sweep, every fifth request carries an illegal digit
    for (int i = 0; i < 30; i++) begin
      int          v;
      logic [15:0] code;
      bit          bad;
      v = int'($urandom_range(0, 9999));
      code = to_bcd(v);
      bad = (i % 5 == 0);
      if (bad) code[4*(i%4) +: 4] = 4'($urandom_range(10, 15));
      run(1'b0, code, cyc, bin, err, ovf, rdy);
      check($sformatf("sw_bin_%h", code), 32'(bin), bad ? 32'd0 : 32'(v));
      check($sformatf("sw_err_%h", code), 32'(err), bad ? 32'd1 : 32'd0);
      check($sformatf("sw_ovf_%h", code), 32'(ovf), 32'd0);
      check($sformatf("sw_lat_%h", code), 32'(cyc), bad ? 32'd1 : 32'd15);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
